// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Column scanner for a 4x4 active-high matrix keypad. Drives one
//               column at a time, samples the synchronised rows, debounces
//               press and release, and freezes the scan while a key is held.
//               Outputs feed keycode_generator.
// Ports       : clk            - system clock
//               rst_n          - asynchronous active-low reset
//               rows[3:0]      - raw keypad rows (async, bit3 = top row)
//               col_drive[3:0] - one-hot column drive (bit3 = first column)
//               col_shift_reg  - column of the last accepted key (one-hot)
//               row_capture    - row pattern of the last accepted key
//               key_pressed    - high while the debounced key is held
//               key_event      - one-cycle pulse as key_pressed rises
// Options     : KEYPAD_MULTIKEY_REJECT_EN - when defined, row patterns with
//               more than one bit set are never accepted as a key.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows,
    output logic [3:0] col_drive,
    output logic [3:0] col_shift_reg,
    output logic [3:0] row_capture,
    output logic       key_pressed,
    output logic       key_event
);

    localparam int c_MAX_CNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
    localparam logic [c_CNT_W-1:0] c_SCAN_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DEB_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [3:0]           r_rows_meta;
    logic [3:0]           r_rows_s;
    logic [3:0]           r_cand;
    logic [3:0]           w_cand_nxt;
    logic [3:0]           r_col;
    logic [3:0]           w_col_nxt;
    logic [3:0]           r_col_shift;
    logic [3:0]           r_row_cap;
    logic                 r_key_pressed;
    logic                 r_key_event;
    logic                 r_accept;
    logic                 w_accept;
    logic                 w_release_done;
    logic                 w_key_valid;
    logic                 w_press_abort;

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    // x & (x-1) clears the lowest set bit; anything left means two or more keys.
    logic w_multi;
    assign w_multi       = |(r_rows_s & (r_rows_s - 4'd1));
    assign w_key_valid   = (r_rows_s != 4'd0) && !w_multi;
    assign w_press_abort = (r_rows_s != r_cand) || w_multi;
`else
    assign w_key_valid   = (r_rows_s != 4'd0);
    assign w_press_abort = (r_rows_s != r_cand);
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_col_nxt      = r_col;
        w_cand_nxt     = r_cand;
        w_accept       = 1'b0;
        w_release_done = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (r_cnt == c_SCAN_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_key_valid) begin
                        w_cand_nxt  = r_rows_s;
                        w_state_nxt = ST_DEB_PRESS;
                    end else begin
                        w_col_nxt = {r_col[0], r_col[3:1]};
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            ST_DEB_PRESS: begin
                // Column stays put so an abort re-dwells the same column.
                if (w_press_abort) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SCAN;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_cnt_nxt   = '0;
                    w_accept    = 1'b1;
                    w_state_nxt = ST_PRESSED;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            ST_PRESSED: begin
                // Pattern changes while still nonzero are ignored on purpose.
                if (r_rows_s == 4'd0) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DEB_RELEASE;
                end
            end
            ST_DEB_RELEASE: begin
                if (r_rows_s != 4'd0) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_PRESSED;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_cnt_nxt      = '0;
                    w_col_nxt      = {r_col[0], r_col[3:1]};
                    w_release_done = 1'b1;
                    w_state_nxt    = ST_SCAN;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows_meta   <= 4'd0;
            r_rows_s      <= 4'd0;
            r_state       <= ST_SCAN;
            r_cnt         <= '0;
            r_col         <= 4'b1000;
            r_cand        <= 4'd0;
            r_col_shift   <= 4'd0;
            r_row_cap     <= 4'd0;
            r_accept      <= 1'b0;
            r_key_pressed <= 1'b0;
            r_key_event   <= 1'b0;
        end else begin
            r_rows_meta <= rows;
            r_rows_s    <= r_rows_meta;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_col       <= w_col_nxt;
            r_cand      <= w_cand_nxt;
            if (w_accept) begin
                r_row_cap   <= r_cand;
                r_col_shift <= r_col;
            end
            // key_pressed/key_event lag the capture by one cycle so the
            // captured code is already stable when key_pressed rises.
            r_accept    <= w_accept;
            r_key_event <= r_accept;
            if (r_accept) begin
                r_key_pressed <= 1'b1;
            end else if (w_release_done) begin
                r_key_pressed <= 1'b0;
            end
        end
    end

    assign col_drive     = r_col;
    assign col_shift_reg = r_col_shift;
    assign row_capture   = r_row_cap;
    assign key_pressed   = r_key_pressed;
    assign key_event     = r_key_event;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Directed self-checking bench for keypad_scanner with
//               SCAN_DIV=8, DEBOUNCE_CYCLES=16. A small keypad model routes
//               the held key's row pattern onto rows while its column is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int c_SCAN_DIV = 8;
    localparam int c_DEB      = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rows;
    logic [3:0] col_drive;
    logic [3:0] col_shift_reg;
    logic [3:0] row_capture;
    logic       key_pressed;
    logic       key_event;

    logic       key_down = 1'b0;
    logic [3:0] key_col  = 4'b0100;
    logic [3:0] key_row  = 4'b0100;

    int n_checks = 0;
    int n_errors = 0;
    int n_events = 0;
    int ev0;
    int lat;
    logic [3:0] prc;
    logic [3:0] pcs;
    logic [3:0] col_prev;

    keypad_scanner #(
        .SCAN_DIV        (c_SCAN_DIV),
        .DEBOUNCE_CYCLES (c_DEB)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rows          (rows),
        .col_drive     (col_drive),
        .col_shift_reg (col_shift_reg),
        .row_capture   (row_capture),
        .key_pressed   (key_pressed),
        .key_event     (key_event)
    );

    always #5 clk = ~clk;

    // Keypad model: the pressed key connects its column to its row(s).
    always_comb rows = (key_down && (col_drive == key_col)) ? key_row : 4'b0000;

    always @(posedge clk) begin
        #1;
        if (rst_n && key_event) n_events++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns cycles waited and the captured outputs one cycle before the rise.
    task automatic wait_press(input int budget, output int l,
                              output logic [3:0] p_rc, output logic [3:0] p_cs);
        l    = 0;
        p_rc = row_capture;
        p_cs = col_shift_reg;
        while (!key_pressed && l < budget) begin
            p_rc = row_capture;
            p_cs = col_shift_reg;
            @(negedge clk);
            l++;
        end
    endtask

    task automatic wait_release(input int budget, output int l);
        l = 0;
        while (key_pressed && l < budget) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_col", col_drive, 4'b1000);
        check("rst_cs", col_shift_reg, 4'b0000);
        check("rst_rc", row_capture, 4'b0000);
        check("rst_kp", key_pressed, 1'b0);
        check("rst_ev", key_event, 1'b0);

        // ---------------- idle scan ----------------
        rst_n = 1'b1;
        cycles(4);  check("scan_c0", col_drive, 4'b1000);
        cycles(8);  check("scan_c1", col_drive, 4'b0100);
        cycles(8);  check("scan_c2", col_drive, 4'b0010);
        cycles(8);  check("scan_c3", col_drive, 4'b0001);
        cycles(8);  check("scan_wrap", col_drive, 4'b1000);
        check("scan_kp", key_pressed, 1'b0);
        check("scan_rc", row_capture, 4'b0000);

        // ---------------- clean press of key '5' ----------------
        key_col = 4'b0100; key_row = 4'b0100;
        ev0 = n_events;
        key_down = 1'b1;
        wait_press(200, lat, prc, pcs);
        check("p5_kp", key_pressed, 1'b1);
        check("p5_ev", key_event, 1'b1);
        check("p5_rc_pre", prc, 4'b0100);
        check("p5_cs_pre", pcs, 4'b0100);
        check("p5_col", col_drive, 4'b0100);
        cycles(1);
        check("p5_ev_pulse", key_event, 1'b0);
        cycles(40);
        check("p5_frozen", col_drive, 4'b0100);
        check("p5_nev", n_events - ev0, 1);

        // ---------------- clean release ----------------
        key_down = 1'b0;
        wait_release(100, lat);
        check("r5_kp", key_pressed, 1'b0);
        check("r5_col", col_drive, 4'b0010);
        check("r5_rc_hold", row_capture, 4'b0100);
        check("r5_cs_hold", col_shift_reg, 4'b0100);

        // ---------------- press with bounces ----------------
        ev0 = n_events;
        key_down = 1'b1;
        lat = 0;
        while (col_drive != 4'b0100 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bnc_reach", col_drive, 4'b0100);
        cycles(10);
        for (int i = 0; i < 3; i++) begin
            key_down = 1'b0;
            cycles(2);
            key_down = 1'b1;
            cycles(12);
            check($sformatf("bnc_kp%0d", i), key_pressed, 1'b0);
        end
        wait_press(200, lat, prc, pcs);
        check("bnc_kp", key_pressed, 1'b1);
        check("bnc_min_lat", (lat + 12) >= c_DEB, 1'b1);
        check("bnc_nev", n_events - ev0, 1);
        check("bnc_rc_pre", prc, 4'b0100);

        // ---------------- release with bounce ----------------
        ev0 = n_events;
        key_down = 1'b0;
        cycles(10);
        key_down = 1'b1;
        cycles(2);
        key_down = 1'b0;
        check("relb_kp_mid", key_pressed, 1'b1);
        cycles(12);
        check("relb_kp_hold", key_pressed, 1'b1);
        wait_release(60, lat);
        check("relb_kp", key_pressed, 1'b0);
        check("relb_min_lat", (lat + 12) >= c_DEB, 1'b1);
        check("relb_col", col_drive, 4'b0010);
        check("relb_nev", n_events - ev0, 0);

        // ---------------- two keys in one column ----------------
        ev0 = n_events;
        key_col = 4'b1000; key_row = 4'b1100;
        key_down = 1'b1;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        cycles(80);
        check("mk_kp", key_pressed, 1'b0);
        check("mk_nev", n_events - ev0, 0);
        col_prev = col_drive;
        cycles(8);
        check("mk_scan", col_drive != col_prev, 1'b1);
        key_down = 1'b0;
        cycles(4);
`else
        wait_press(200, lat, prc, pcs);
        check("mk_kp", key_pressed, 1'b1);
        check("mk_rc", row_capture, 4'b1100);
        check("mk_cs", col_shift_reg, 4'b1000);
        key_down = 1'b0;
        wait_release(100, lat);
        check("mk_rel", key_pressed, 1'b0);
`endif

        // ---------------- reset while a key is held ----------------
        key_col = 4'b0100; key_row = 4'b0100;
        key_down = 1'b1;
        wait_press(200, lat, prc, pcs);
        check("rh_kp", key_pressed, 1'b1);
        cycles(3);
        rst_n = 1'b0;
        #1;
        check("rh_kp0", key_pressed, 1'b0);
        check("rh_col", col_drive, 4'b1000);
        check("rh_rc", row_capture, 4'b0000);
        check("rh_cs", col_shift_reg, 4'b0000);
        check("rh_ev", key_event, 1'b0);
        key_down = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(4);  check("rh_scan0", col_drive, 4'b1000);
        cycles(8);  check("rh_scan1", col_drive, 4'b0100);
        check("rh_kp_idle", key_pressed, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
